// File: rtl/rr_mux2_arbiter_pkg.sv
// rr_mux2_pkg: shared types and constants for the two-requester round-robin
// arbiter. Holds the FSM state encoding and the one-hot grant values.
package rr_mux2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_S0   = 2'b01;
  localparam logic [1:0] GNT_S1   = 2'b10;

  // One-hot grant that a given state presents on gnt.
  function automatic logic [1:0] gnt_of(input arb_state_e st);
    logic [1:0] g;
    case (st)
      GNT0:    g = GNT_S0;
      GNT1:    g = GNT_S1;
      default: g = GNT_NONE;
    endcase
    return g;
  endfunction

endpackage : rr_mux2_pkg

// File: rtl/rr_mux2_arbiter_if.sv
// rr_mux2_arbiter_if: bundles the two requester streams, the shared output
// channel and the grant vector. The arbiter connects through the master
// modport (it drives the shared channel); the environment uses slave.
interface rr_mux2_arbiter_if #(
  parameter int DATA_W = 8
);

  logic              s0_valid;
  logic              s0_ready;
  logic [DATA_W-1:0] s0_data;
  logic              s0_last;

  logic              s1_valid;
  logic              s1_ready;
  logic [DATA_W-1:0] s1_data;
  logic              s1_last;

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  logic [1:0]        gnt;

  modport master (
    input  s0_valid, s0_data, s0_last,
    input  s1_valid, s1_data, s1_last,
    input  m_ready,
    output s0_ready, s1_ready,
    output m_valid, m_data, m_last,
    output gnt
  );

  modport slave (
    output s0_valid, s0_data, s0_last,
    output s1_valid, s1_data, s1_last,
    output m_ready,
    input  s0_ready, s1_ready,
    input  m_valid, m_data, m_last,
    input  gnt
  );

endinterface : rr_mux2_arbiter_if

// File: rtl/rr_mux2_arbiter_mux2_bus.sv
// mux2_bus: plain WIDTH-bit 2:1 multiplexer. Used as the arbiter datapath
// carrying {last, data} from the selected requester.
module mux2_bus #(
  parameter int WIDTH = 9
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out
);

  // Select requester 1 when sel is high, otherwise requester 0.
  always_comb begin
    if (sel) begin
      out = in1;
    end else begin
      out = in0;
    end
  end

endmodule : mux2_bus

// File: rtl/rr_mux2_arbiter.sv
// rr_mux2_arbiter: round-robin arbiter sharing one valid/ready output channel
// between two requesters. The FSM owns the mux select; the granted
// requester's valid/data/last flow combinationally to the output and
// m_ready flows back to the granted requester only.
//
// Build option ARB_PKT_LOCK_EN:
//   defined   - grant is held for a whole packet, released on the m_last beat
//   undefined - grant is released after every transferred beat
module rr_mux2_arbiter
  import rr_mux2_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  rr_mux2_arbiter_if.master   bus
);

  arb_state_e        state_r;
  logic [1:0]        gnt_r;
  logic              ptr_r;

  logic              sel_s;
  logic              m_valid_s;
  logic              s0_ready_s;
  logic              s1_ready_s;
  logic              xfer_s;
  logic              rel_s;
  logic [DATA_W:0]   mux_in0_s;
  logic [DATA_W:0]   mux_in1_s;
  logic [DATA_W:0]   mux_out_s;

  // Datapath: gnt[1] picks requester 1; idle leaves requester 0 selected.
  assign sel_s     = gnt_r[1];
  assign mux_in0_s = {bus.s0_last, bus.s0_data};
  assign mux_in1_s = {bus.s1_last, bus.s1_data};

  mux2_bus #(
    .WIDTH (DATA_W + 1)
  ) u_mux2_bus (
    .sel (sel_s),
    .in0 (mux_in0_s),
    .in1 (mux_in1_s),
    .out (mux_out_s)
  );

  assign bus.m_data   = mux_out_s[DATA_W-1:0];
  assign bus.m_last   = mux_out_s[DATA_W];
  assign bus.m_valid  = m_valid_s;
  assign bus.s0_ready = s0_ready_s;
  assign bus.s1_ready = s1_ready_s;
  assign bus.gnt      = gnt_r;

  // Route valid forward and ready back through the granted path only.
  always_comb begin
    m_valid_s  = 1'b0;
    s0_ready_s = 1'b0;
    s1_ready_s = 1'b0;
    case (gnt_r)
      GNT_S0: begin
        m_valid_s  = bus.s0_valid;
        s0_ready_s = bus.m_ready;
      end
      GNT_S1: begin
        m_valid_s  = bus.s1_valid;
        s1_ready_s = bus.m_ready;
      end
      default: begin
        m_valid_s  = 1'b0;
        s0_ready_s = 1'b0;
        s1_ready_s = 1'b0;
      end
    endcase
  end

  // Release event: end of a packet when locking, otherwise every beat.
  always_comb begin
    xfer_s = m_valid_s & bus.m_ready;
`ifdef ARB_PKT_LOCK_EN
    rel_s  = xfer_s & mux_out_s[DATA_W];
`else
    rel_s  = xfer_s;
`endif
  end

  // Arbitration FSM: state, registered one-hot grant and round-robin pointer.
  // The grant only moves on a release (a completed transfer) or when the
  // granted requester shows no beat, so m_data/m_last never change under a
  // stalled valid beat. A granted requester with no beat hands over to the
  // other side (or idles) so neither a dropped valid nor a quiet channel can
  // strand a waiting requester; the pointer is untouched in that case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      gnt_r   <= GNT_NONE;
      ptr_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.s0_valid && (!bus.s1_valid || !ptr_r)) begin
            state_r <= GNT0;
            gnt_r   <= gnt_of(GNT0);
          end else if (bus.s1_valid) begin
            state_r <= GNT1;
            gnt_r   <= gnt_of(GNT1);
          end else begin
            state_r <= IDLE;
            gnt_r   <= gnt_of(IDLE);
          end
        end
        GNT0: begin
          if (rel_s) begin
            ptr_r <= 1'b1;
            if (bus.s1_valid) begin
              state_r <= GNT1;
              gnt_r   <= gnt_of(GNT1);
            end else if (bus.s0_valid) begin
              state_r <= GNT0;
              gnt_r   <= gnt_of(GNT0);
            end else begin
              state_r <= IDLE;
              gnt_r   <= gnt_of(IDLE);
            end
          end else if (!bus.s0_valid) begin
            if (bus.s1_valid) begin
              state_r <= GNT1;
              gnt_r   <= gnt_of(GNT1);
            end else begin
              state_r <= IDLE;
              gnt_r   <= gnt_of(IDLE);
            end
          end else begin
            state_r <= GNT0;
            gnt_r   <= gnt_of(GNT0);
          end
        end
        GNT1: begin
          if (rel_s) begin
            ptr_r <= 1'b0;
            if (bus.s0_valid) begin
              state_r <= GNT0;
              gnt_r   <= gnt_of(GNT0);
            end else if (bus.s1_valid) begin
              state_r <= GNT1;
              gnt_r   <= gnt_of(GNT1);
            end else begin
              state_r <= IDLE;
              gnt_r   <= gnt_of(IDLE);
            end
          end else if (!bus.s1_valid) begin
            if (bus.s0_valid) begin
              state_r <= GNT0;
              gnt_r   <= gnt_of(GNT0);
            end else begin
              state_r <= IDLE;
              gnt_r   <= gnt_of(IDLE);
            end
          end else begin
            state_r <= GNT1;
            gnt_r   <= gnt_of(GNT1);
          end
        end
        default: begin
          state_r <= IDLE;
          gnt_r   <= GNT_NONE;
        end
      endcase
    end
  end

endmodule : rr_mux2_arbiter

// File: tb/tb_rr_mux2_arbiter.sv
// tb_rr_mux2_arbiter: directed bench for rr_mux2_arbiter. Inputs change on
// the falling edge and outputs are checked 1 time unit later, away from the
// rising edge. Expected values are hand-derived for each step.
module tb_rr_mux2_arbiter;
  import rr_mux2_pkg::*;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;
  logic [7:0] d;

  rr_mux2_arbiter_if #(.DATA_W(8)) bus ();

  rr_mux2_arbiter #(.DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.s0_valid = 1'b1;
    bus.s1_valid = 1'b1;
    bus.s0_data  = 8'hA5;
    bus.s1_data  = 8'h5A;
    bus.s0_last  = 1'b1;
    bus.s1_last  = 1'b1;
    bus.m_ready  = 1'b1;

    // Reset held with both requesters valid
    cyc(); cyc(); #1;
    chk("rst_gnt",      32'(bus.gnt),      32'h0);
    chk("rst_m_valid",  32'(bus.m_valid),  32'h0);
    chk("rst_s0_ready", 32'(bus.s0_ready), 32'h0);
    chk("rst_s1_ready", 32'(bus.s1_ready), 32'h0);
    chk("rst_m_data",   32'(bus.m_data),   32'hA5);

    // Test 1: release reset, first grant one cycle later to requester 0
    cyc(); rst_n = 1'b1; #1;
    chk("t1_c1_gnt",     32'(bus.gnt),     32'h0);
    chk("t1_c1_m_valid", 32'(bus.m_valid), 32'h0);
    cyc(); #1;
    chk("t1_c2_gnt",     32'(bus.gnt),     32'h1);
    chk("t1_c2_m_data",  32'(bus.m_data),  32'hA5);
    chk("t1_c2_m_valid", 32'(bus.m_valid), 32'h1);

    // Test 2: both streaming single-beat packets, grant alternates
    for (int i = 0; i < 5; i++) begin
      cyc();
      bus.s0_data = 8'h11;
      bus.s1_data = 8'h22;
      #1;
      chk("t2_gnt",    32'(bus.gnt),    (i % 2 == 0) ? 32'h2  : 32'h1);
      chk("t2_m_data", 32'(bus.m_data), (i % 2 == 0) ? 32'h22 : 32'h11);
    end

    // Test 3: backpressure while GNT0 with requester 1 waiting
    cyc();
    bus.m_ready = 1'b0;
    bus.s0_data = 8'h3C;
    #1;
    chk("t3_gnt",      32'(bus.gnt),      32'h1);
    chk("t3_m_data",   32'(bus.m_data),   32'h3C);
    chk("t3_s1_ready", 32'(bus.s1_ready), 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk("t3_hold_gnt",      32'(bus.gnt),      32'h1);
      chk("t3_hold_m_data",   32'(bus.m_data),   32'h3C);
      chk("t3_hold_s1_ready", 32'(bus.s1_ready), 32'h0);
      chk("t3_hold_m_valid",  32'(bus.m_valid),  32'h1);
    end

    // Test 4: requester 0 sends a 4-beat packet while requester 1 is valid
`ifdef ARB_PKT_LOCK_EN
    for (int b = 0; b < 4; b++) begin
      cyc();
      bus.m_ready = 1'b1;
      d = 8'h40 + 8'(b);
      bus.s0_data = d;
      bus.s0_last = (b == 3);
      #1;
      chk("t4_lock_gnt",    32'(bus.gnt),    32'h1);
      chk("t4_lock_m_data", 32'(bus.m_data), 32'(d));
    end
    cyc(); #1;
    chk("t4_lock_s1_gnt",    32'(bus.gnt),    32'h2);
    chk("t4_lock_s1_m_data", 32'(bus.m_data), 32'h22);
`else
    for (int b = 0; b < 4; b++) begin
      cyc();
      bus.m_ready = 1'b1;
      d = 8'h40 + 8'(b);
      bus.s0_data = d;
      bus.s0_last = (b == 3);
      #1;
      chk("t4_s0_gnt",    32'(bus.gnt),    32'h1);
      chk("t4_s0_m_data", 32'(bus.m_data), 32'(d));
      cyc(); #1;
      chk("t4_s1_gnt",    32'(bus.gnt),    32'h2);
      chk("t4_s1_m_data", 32'(bus.m_data), 32'h22);
    end
`endif

    // Test 5: only requester 1 valid, three single-beat packets
    cyc();
    bus.s0_valid = 1'b0;
    bus.s0_last  = 1'b1;
    #1;
    chk("t5_handover_gnt",     32'(bus.gnt),     32'h1);
    chk("t5_handover_m_valid", 32'(bus.m_valid), 32'h0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      d = 8'h71 + 8'(k);
      bus.s1_data = d;
      #1;
      chk("t5_gnt",     32'(bus.gnt),     32'h2);
      chk("t5_m_data",  32'(bus.m_data),  32'(d));
      chk("t5_m_valid", 32'(bus.m_valid), 32'h1);
    end
    cyc();
    bus.s1_valid = 1'b0;
    #1;
    chk("t5_drop_gnt",     32'(bus.gnt),     32'h2);
    chk("t5_drop_m_valid", 32'(bus.m_valid), 32'h0);
    cyc(); #1;
    chk("t5_idle_gnt", 32'(bus.gnt), 32'h0);

    // Test 6: async reset mid-packet in GNT1 with ptr pointing at requester 1
    cyc();
    bus.s0_valid = 1'b1;
    bus.s1_valid = 1'b1;
    bus.s0_data  = 8'h81;
    bus.s1_data  = 8'h91;
    bus.s1_last  = 1'b0;
    bus.m_ready  = 1'b1;
    #1;
    chk("t6_idle_gnt", 32'(bus.gnt), 32'h0);
    cyc(); #1;
    chk("t6_s0_gnt",    32'(bus.gnt),    32'h1);
    chk("t6_s0_m_data", 32'(bus.m_data), 32'h81);
    cyc();
    bus.m_ready = 1'b0;
    #1;
    chk("t6_s1_gnt",     32'(bus.gnt),     32'h2);
    chk("t6_s1_m_data",  32'(bus.m_data),  32'h91);
    chk("t6_s1_m_valid", 32'(bus.m_valid), 32'h1);
    cyc();
    bus.m_ready = 1'b1;
    #1;
    chk("t6_pre_s1_ready", 32'(bus.s1_ready), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_gnt",      32'(bus.gnt),      32'h0);
    chk("t6_async_m_valid",  32'(bus.m_valid),  32'h0);
    chk("t6_async_s1_ready", 32'(bus.s1_ready), 32'h0);
    chk("t6_async_s0_ready", 32'(bus.s0_ready), 32'h0);
    cyc();
    rst_n = 1'b1;
    #1;
    chk("t6_rel_gnt", 32'(bus.gnt), 32'h0);
    cyc(); #1;
    chk("t6_ptr0_gnt",    32'(bus.gnt),    32'h1);
    chk("t6_ptr0_m_data", 32'(bus.m_data), 32'h81);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_rr_mux2_arbiter
